ls_queue: RTL and testbench

//   Parametrised in-order load/store queue between dispatcher and LS unit.

---
 rtl/ls_pkg.sv | 16 +
 rtl/cdb_snoop.sv | 25 ++
 rtl/ls_queue.sv | 152 +++++++++++++++
 tb/tb_ls_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// ls_pkg: shared constants and default widths for the load/store queue.
package ls_pkg;
    localparam int DEPTH_D  = 8;
    localparam int CDB_N_D  = 2;
    localparam int DATA_W_D = 32;
    localparam int TAG_W_D  = 4;
    localparam int NAME_W_D = 5;
    localparam int OP_W_D   = 6;
    localparam int TAG_FREE  = 0;
    localparam int NAME_FREE = 0;
    localparam int OP_NOP    = 0;
    // Entry layout: op, name, imm, then per source operand a tag and a value.
    typedef enum logic [2:0] {
        F_OP, F_NAME, F_IMM, F_TAG_O, F_TAG_T, F_DATA_O, F_DATA_T
    } entry_field_e;
endpackage

// File: rtl/cdb_snoop.sv
// cdb_snoop: compares one waiting tag against all CDB channels; lowest channel wins.
module cdb_snoop
    import ls_pkg::*;
#(
    parameter int CDB_N  = CDB_N_D,
    parameter int TAG_W  = TAG_W_D,
    parameter int DATA_W = DATA_W_D
) (
    input  logic [TAG_W-1:0]        tag,
    input  logic [CDB_N-1:0]        cdb_en,
    input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
    input  logic [CDB_N*DATA_W-1:0] cdb_data,
    output logic                    hit,
    output logic [DATA_W-1:0]       data
);
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = CDB_N - 1; k >= 0; k--)
            if (cdb_en[k] && tag != TAG_W'(TAG_FREE) && cdb_tag[k*TAG_W +: TAG_W] == tag) begin
                hit  = 1'b1;
                data = cdb_data[k*DATA_W +: DATA_W];
            end
    end
endmodule

// File: rtl/ls_queue.sv
// ls_queue: in-order load/store queue with CDB operand wakeup and a registered issue stage.
module ls_queue
    import ls_pkg::*;
#(
    parameter int DEPTH  = DEPTH_D,
    parameter int CDB_N  = CDB_N_D,
    parameter int DATA_W = DATA_W_D,
    parameter int TAG_W  = TAG_W_D,
    parameter int NAME_W = NAME_W_D,
    parameter int OP_W   = OP_W_D,
    parameter logic [TAG_W-$clog2(DEPTH)-1:0] LS_PREFIX = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [CDB_N-1:0]             cdb_en,
    input  logic [CDB_N*TAG_W-1:0]       cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]      cdb_data,
    input  logic                         alloc_en,
    input  logic [OP_W-1:0]              alloc_op,
    input  logic [NAME_W-1:0]            alloc_name,
    input  logic [DATA_W-1:0]            alloc_imm,
    input  logic [TAG_W-1:0]             alloc_tag_o,
    input  logic [TAG_W-1:0]             alloc_tag_t,
    input  logic [DATA_W-1:0]            alloc_data_o,
    input  logic [DATA_W-1:0]            alloc_data_t,
    output logic                         alloc_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   free_cnt,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [OP_W-1:0]              issue_op,
    output logic [NAME_W-1:0]            issue_name,
    output logic [DATA_W-1:0]            issue_imm,
    output logic [DATA_W-1:0]            issue_data_o,
    output logic [DATA_W-1:0]            issue_data_t,
    output logic [TAG_W-1:0]             issue_tag
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [OP_W-1:0]   op_q     [DEPTH];
    logic [NAME_W-1:0] name_q   [DEPTH];
    logic [DATA_W-1:0] imm_q    [DEPTH];
    logic [TAG_W-1:0]  tag_o_q  [DEPTH];
    logic [TAG_W-1:0]  tag_t_q  [DEPTH];
    logic [DATA_W-1:0] data_o_q [DEPTH];
    logic [DATA_W-1:0] data_t_q [DEPTH];
    logic [DATA_W-1:0] wd_o     [DEPTH];
    logic [DATA_W-1:0] wd_t     [DEPTH];
    logic [DEPTH-1:0]  hit_o, hit_t;
    logic [IDX_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic              a_hit_o, a_hit_t, head_rdy, pop, alloc_do;
    logic [DATA_W-1:0] a_d_o, a_d_t;

    assign alloc_rdy = count != CNT_W'(DEPTH);
    assign free_cnt  = CNT_W'(DEPTH) - count;
    assign alloc_do  = alloc_en && alloc_rdy;
    assign head_rdy  = count != '0 && tag_o_q[head] == TAG_W'(TAG_FREE) && tag_t_q[head] == TAG_W'(TAG_FREE);
    assign pop       = head_rdy && (!issue_valid || issue_ready);

    for (genvar i = 0; i < DEPTH; i++) begin : g_e
        cdb_snoop #(.CDB_N(CDB_N), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_o (
            .tag(tag_o_q[i]), .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
            .hit(hit_o[i]), .data(wd_o[i]));
        cdb_snoop #(.CDB_N(CDB_N), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_t (
            .tag(tag_t_q[i]), .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
            .hit(hit_t[i]), .data(wd_t[i]));
    end

    // Bypass: a source produced on the CDB in the allocation cycle is captured as ready.
    cdb_snoop #(.CDB_N(CDB_N), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_ao (
        .tag(alloc_tag_o), .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .hit(a_hit_o), .data(a_d_o));
    cdb_snoop #(.CDB_N(CDB_N), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_at (
        .tag(alloc_tag_t), .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .hit(a_hit_t), .data(a_d_t));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + IDX_W'(pop);
            tail  <= tail + IDX_W'(alloc_do);
            count <= count + CNT_W'(alloc_do) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]     <= '0;
                name_q[i]   <= '0;
                imm_q[i]    <= '0;
                tag_o_q[i]  <= '0;
                tag_t_q[i]  <= '0;
                data_o_q[i] <= '0;
                data_t_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit_o[i]) begin
                    tag_o_q[i]  <= '0;
                    data_o_q[i] <= wd_o[i];
                end
                if (hit_t[i]) begin
                    tag_t_q[i]  <= '0;
                    data_t_q[i] <= wd_t[i];
                end
            end
            if (alloc_do) begin
                op_q[tail]     <= alloc_op;
                name_q[tail]   <= alloc_name;
                imm_q[tail]    <= alloc_imm;
                tag_o_q[tail]  <= a_hit_o ? '0 : alloc_tag_o;
                tag_t_q[tail]  <= a_hit_t ? '0 : alloc_tag_t;
                data_o_q[tail] <= a_hit_o ? a_d_o : alloc_data_o;
                data_t_q[tail] <= a_hit_t ? a_d_t : alloc_data_t;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid  <= 1'b0;
            issue_op     <= '0;
            issue_name   <= '0;
            issue_imm    <= '0;
            issue_data_o <= '0;
            issue_data_t <= '0;
            issue_tag    <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (pop) begin
            issue_valid  <= 1'b1;
            issue_op     <= op_q[head];
            issue_name   <= name_q[head];
            issue_imm    <= imm_q[head];
            issue_data_o <= data_o_q[head];
            issue_data_t <= data_t_q[head];
            issue_tag    <= name_q[head] != NAME_W'(NAME_FREE) ? {LS_PREFIX, head} : '0;
        end else if (issue_ready) begin
            issue_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ls_queue.sv
// tb_ls_queue: randomized and directed checks of ls_queue against a queue-based reference model.
module tb_ls_queue;
    logic        clk = 1'b0, rst = 1'b0, flush = 1'b0;
    logic [1:0]  cdb_en = '0;
    logic [7:0]  cdb_tag = '0;
    logic [63:0] cdb_data = '0;
    logic        alloc_en = 1'b0, issue_ready = 1'b1;
    logic [5:0]  alloc_op = '0;
    logic [4:0]  alloc_name = '0;
    logic [31:0] alloc_imm = '0, alloc_data_o = '0, alloc_data_t = '0;
    logic [3:0]  alloc_tag_o = '0, alloc_tag_t = '0;
    logic        alloc_rdy, issue_valid;
    logic [3:0]  free_cnt, issue_tag;
    logic [5:0]  issue_op;
    logic [4:0]  issue_name;
    logic [31:0] issue_imm, issue_data_o, issue_data_t;

    always #5 clk = ~clk;

    ls_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alloc_en(alloc_en), .alloc_op(alloc_op), .alloc_name(alloc_name), .alloc_imm(alloc_imm),
        .alloc_tag_o(alloc_tag_o), .alloc_tag_t(alloc_tag_t),
        .alloc_data_o(alloc_data_o), .alloc_data_t(alloc_data_t),
        .alloc_rdy(alloc_rdy), .free_cnt(free_cnt),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_name(issue_name), .issue_imm(issue_imm),
        .issue_data_o(issue_data_o), .issue_data_t(issue_data_t), .issue_tag(issue_tag)
    );

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  name;
        logic [31:0] imm, d_o, d_t;
        logic [3:0]  t_o, t_t;
        int          slot;
    } ent_t;

    ent_t mq[$];
    ent_t exp_q[$];
    ent_t e, e2;
    bit   iv = 1'b0;
    int   mtail = 0, sz = 0, n_hs = 0, hs0 = 0;
    int   checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Returns {tag, data} after a possible CDB capture; the lowest matching channel wins.
    function automatic logic [35:0] wake(input logic [3:0] t, input logic [31:0] d);
        logic [3:0]  tt = t;
        logic [31:0] dd = d;
        for (int k = 0; k < 2; k++)
            if (tt != 0 && cdb_en[k] && cdb_tag[k*4 +: 4] == tt) begin
                tt = 4'd0;
                dd = cdb_data[k*32 +: 32];
            end
        return {tt, dd};
    endfunction

    function automatic logic [3:0] exp_tag(input ent_t x);
        return x.name != 0 ? {1'b1, 3'(x.slot)} : 4'd0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            mq.delete();
            exp_q.delete();
            iv = 1'b0;
            mtail = 0;
        end else begin
            sz = mq.size();
            if (sz > 0 && mq[0].t_o == 0 && mq[0].t_t == 0 && (!iv || issue_ready)) begin
                exp_q.push_back(mq.pop_front());
                iv = 1'b1;
            end else if (issue_ready) iv = 1'b0;
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                {e.t_o, e.d_o} = wake(e.t_o, e.d_o);
                {e.t_t, e.d_t} = wake(e.t_t, e.d_t);
                mq[i] = e;
            end
            if (alloc_en && sz < 8) begin
                e.op = alloc_op;
                e.name = alloc_name;
                e.imm = alloc_imm;
                {e.t_o, e.d_o} = wake(alloc_tag_o, alloc_data_o);
                {e.t_t, e.d_t} = wake(alloc_tag_t, alloc_data_t);
                e.slot = mtail;
                mtail = (mtail + 1) % 8;
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("free_cnt", 64'(free_cnt), 64'(8 - mq.size()));
            chk("alloc_rdy", 64'(alloc_rdy), 64'(mq.size() != 8));
            chk("issue_valid", 64'(issue_valid), 64'(iv));
            if (issue_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL issue_unexpected actual=op%0h expected=none at %0t", issue_op, $time);
                end else begin
                    e2 = exp_q[0];
                    chk("issue_op", 64'(issue_op), 64'(e2.op));
                    chk("issue_name", 64'(issue_name), 64'(e2.name));
                    chk("issue_imm", 64'(issue_imm), 64'(e2.imm));
                    chk("issue_data_o", 64'(issue_data_o), 64'(e2.d_o));
                    chk("issue_data_t", 64'(issue_data_t), 64'(e2.d_t));
                    chk("issue_tag", 64'(issue_tag), 64'(exp_tag(e2)));
                    if (issue_ready) begin
                        void'(exp_q.pop_front());
                        n_hs++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_alloc(input logic [5:0] op, input logic [4:0] nm, input logic [31:0] imm,
                             input logic [3:0] to, input logic [3:0] tt,
                             input logic [31:0] dox, input logic [31:0] dtx);
        alloc_en = 1'b1;
        alloc_op = op;
        alloc_name = nm;
        alloc_imm = imm;
        alloc_tag_o = to;
        alloc_tag_t = tt;
        alloc_data_o = dox;
        alloc_data_t = dtx;
    endtask

    task automatic rand_inputs();
        set_alloc(6'($urandom), 5'($urandom),  $urandom,
                  ($urandom % 3 == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                  ($urandom % 3 == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                  $urandom, $urandom);
        alloc_en = ($urandom % 2) == 0;
        cdb_en = 2'($urandom);
        cdb_tag = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
        cdb_data = {$urandom, $urandom};
        issue_ready = ($urandom % 4) != 0;
        flush = ($urandom % 100) == 0;
    endtask

    initial begin
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("reset_free", 64'(free_cnt), 64'd8);
        chk("reset_rdy", 64'(alloc_rdy), 64'd1);
        chk("reset_valid", 64'(issue_valid), 64'd0);
        // Ready entry: visible in the issue stage on the second edge.
        set_alloc(6'd3, 5'd5, 32'h11, 4'd0, 4'd0, 32'h1, 32'h2);
        step();
        alloc_en = 1'b0;
        chk("t2_not_yet", 64'(issue_valid), 64'd0);
        step();
        chk("t2_valid", 64'(issue_valid), 64'd1);
        chk("t2_tag", 64'(issue_tag), 64'h8);
        chk("t2_op", 64'(issue_op), 64'd3);
        // Wake via channel 1.
        set_alloc(6'd4, 5'd6, 32'h22, 4'd5, 4'd0, 32'h0, 32'h3);
        step();
        alloc_en = 1'b0;
        cdb_en = 2'b10;
        cdb_tag = {4'd5, 4'd0};
        cdb_data = {32'hDEAD, 32'h0};
        step();
        cdb_en = 2'b00;
        chk("t3_wait", 64'(issue_valid), 64'd0);
        step();
        chk("t3_valid", 64'(issue_valid), 64'd1);
        chk("t3_data", 64'(issue_data_o), 64'hDEAD);
        // Allocation bypass from channel 0.
        set_alloc(6'd5, 5'd7, 32'h33, 4'd0, 4'd7, 32'h4, 32'h0);
        cdb_en = 2'b01;
        cdb_tag = {4'd0, 4'd7};
        cdb_data = {32'h0, 32'h1234};
        step();
        alloc_en = 1'b0;
        cdb_en = 2'b00;
        chk("t4_wait", 64'(issue_valid), 64'd0);
        step();
        chk("t4_valid", 64'(issue_valid), 64'd1);
        chk("t4_data", 64'(issue_data_t), 64'h1234);
        chk("t4_tag", 64'(issue_tag), 64'hA);
        step();
        // Fill with the LS unit stalled: one entry parks in the issue stage, eight queue, the last is dropped.
        issue_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_alloc(6'(i + 10), (i == 4) ? 5'd0 : 5'(i + 1), 32'(i), 4'd0, 4'd0, 32'(i), 32'(i));
            step();
        end
        alloc_en = 1'b0;
        chk("t5_free", 64'(free_cnt), 64'd0);
        chk("t5_rdy", 64'(alloc_rdy), 64'd0);
        chk("t5_valid", 64'(issue_valid), 64'd1);
        chk("t5_head_op", 64'(issue_op), 64'd10);
        hs0 = n_hs;
        issue_ready = 1'b1;
        repeat (15) step();
        chk("t5_drained", 64'(n_hs - hs0), 64'd9);
        chk("t5_free_after", 64'(free_cnt), 64'd8);
        // Blocked head, younger ready entry, then flush.
        set_alloc(6'd20, 5'd1, 32'h0, 4'd4, 4'd0, 32'h0, 32'h0);
        step();
        set_alloc(6'd21, 5'd2, 32'h0, 4'd0, 4'd0, 32'h0, 32'h0);
        step();
        alloc_en = 1'b0;
        repeat (2) step();
        chk("t6_blocked", 64'(issue_valid), 64'd0);
        chk("t6_free", 64'(free_cnt), 64'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t6_flush_valid", 64'(issue_valid), 64'd0);
        chk("t6_flush_free", 64'(free_cnt), 64'd8);
        cdb_en = 2'b01;
        cdb_tag = {4'd0, 4'd4};
        step();
        cdb_en = 2'b00;
        repeat (3) step();
        chk("t6_no_issue", 64'(issue_valid), 64'd0);
        // Random traffic.
        repeat (3000) begin
            rand_inputs();
            step();
        end
        flush = 1'b0;
        issue_ready = 1'b0;
        repeat (20) begin
            rand_inputs();
            flush = 1'b0;
            issue_ready = 1'b0;
            step();
        end
        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t1_valid", 64'(issue_valid), 64'd0);
        chk("t1_free", 64'(free_cnt), 64'd8);
        chk("t1_rdy", 64'(alloc_rdy), 64'd1);
        alloc_en = 1'b0;
        cdb_en = 2'b00;
        issue_ready = 1'b1;
        step();
        rst = 1'b1;
        repeat (3) step();
        chk("t1_after_valid", 64'(issue_valid), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
